// File: rtl/t_decoder_if.sv
// Signal bundle between a toggle-event decoder and its consumer.
// The master drives the toggle line and the clear; the slave (decoder) returns the events.
interface t_decoder_if #(
  parameter int CNT_W = 8
);
  logic             q_in;
  logic             cnt_clr;
  logic             level;
  logic             t_out;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] toggle_cnt;
  logic             ovf;

  modport master (
    output q_in, cnt_clr,
    input  level, t_out, rise, fall, toggle_cnt, ovf
  );

  modport slave (
    input  q_in, cnt_clr,
    output level, t_out, rise, fall, toggle_cnt, ovf
  );
endinterface

// File: rtl/t_decoder.sv
// Toggle-event decoder: synchronizes and filters a toggle-encoded level and emits one-cycle events.
// Define T_DECODER_FILTER_EN to build the FILTER_CYCLES glitch filter; otherwise every change of s fires.
module t_decoder #(
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        reset,
  t_decoder_if.slave  bus
);

  if (FILTER_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("t_decoder: FILTER_CYCLES and CNT_W must both be >= 1");
  end

  localparam logic [1:0] STABLE_L = 2'd0;
  localparam logic [1:0] STABLE_H = 2'd2;

  logic             s1;
  logic             s;
  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic             fire;
  logic             level;
  logic             t_out;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] toggle_cnt;
  logic             ovf;

`ifdef T_DECODER_FILTER_EN
  localparam logic [1:0] CHK_H = 2'd1;
  localparam logic [1:0] CHK_L = 2'd3;
  localparam int STAB_W = $clog2(FILTER_CYCLES + 1);
  // stab counts agreeing samples already taken; the next agreeing one completes the filter.
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILTER_CYCLES - 1);

  logic [STAB_W-1:0] stab;
  logic [STAB_W-1:0] stab_nx;

  // NOTE: every output of this block gets a default first, so no path leaves a value held
  // and no latch is inferred.
  always_comb begin
    state_nx = state;
    stab_nx  = stab;
    fire     = 1'b0;
    case (state)
      STABLE_L: begin
        if (s) begin
          if (FILTER_CYCLES == 1) begin
            state_nx = STABLE_H;
            fire     = 1'b1;
          end else begin
            state_nx = CHK_H;
            stab_nx  = STAB_W'(1);
          end
        end
      end
      CHK_H: begin
        if (!s) begin
          state_nx = STABLE_L;
          stab_nx  = '0;
        end else if (stab == STAB_LAST) begin
          state_nx = STABLE_H;
          stab_nx  = '0;
          fire     = 1'b1;
        end else begin
          stab_nx  = stab + STAB_W'(1);
        end
      end
      STABLE_H: begin
        if (!s) begin
          if (FILTER_CYCLES == 1) begin
            state_nx = STABLE_L;
            fire     = 1'b1;
          end else begin
            state_nx = CHK_L;
            stab_nx  = STAB_W'(1);
          end
        end
      end
      CHK_L: begin
        if (s) begin
          state_nx = STABLE_H;
          stab_nx  = '0;
        end else if (stab == STAB_LAST) begin
          state_nx = STABLE_L;
          stab_nx  = '0;
          fire     = 1'b1;
        end else begin
          stab_nx  = stab + STAB_W'(1);
        end
      end
      default: begin
        state_nx = STABLE_L;
        stab_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stab <= '0;
    end else begin
      stab <= stab_nx;
    end
  end
`else
  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    case (state)
      STABLE_L: begin
        if (s) begin
          state_nx = STABLE_H;
          fire     = 1'b1;
        end
      end
      STABLE_H: begin
        if (!s) begin
          state_nx = STABLE_L;
          fire     = 1'b1;
        end
      end
      default: state_nx = STABLE_L;
    endcase
  end
`endif

  // NOTE: all state here uses non-blocking assignments so every flop samples the values
  // from before the edge; s1 -> s is a true two-stage synchronizer only because of that.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= 1'b0;
      s          <= 1'b0;
      state      <= STABLE_L;
      level      <= 1'b0;
      t_out      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      toggle_cnt <= '0;
      ovf        <= 1'b0;
    end else begin
      s1    <= bus.q_in;
      s     <= s1;
      state <= state_nx;
      t_out <= fire;
      rise  <= fire & ~level;
      fall  <= fire & level;
      if (fire) begin
        level <= ~level;
      end
      // A clear coinciding with an event keeps that event in the count.
      if (bus.cnt_clr) begin
        toggle_cnt <= fire ? CNT_W'(1) : '0;
        ovf        <= 1'b0;
      end else if (fire) begin
        toggle_cnt <= toggle_cnt + CNT_W'(1);
        if (&toggle_cnt) begin
          ovf <= 1'b1;
        end
      end
    end
  end

  assign bus.level      = level;
  assign bus.t_out      = t_out;
  assign bus.rise       = rise;
  assign bus.fall       = fall;
  assign bus.toggle_cnt = toggle_cnt;
  assign bus.ovf        = ovf;

endmodule

// File: tb/tb_t_decoder.sv
// Self-checking bench for t_decoder: directed scenarios plus random toggling against a
// reference that accepts a level once it has disagreed with the current one for F_EFF samples.
module tb_t_decoder;

  localparam int FILTER_CYCLES = 4;
  localparam int CNT_W         = 3;
`ifdef T_DECODER_FILTER_EN
  localparam int F_EFF = FILTER_CYCLES;
`else
  localparam int F_EFF = 1;
`endif
  localparam int LAT = F_EFF + 2;   // negedges from an input change to the visible pulse
  localparam int MOD = 1 << CNT_W;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  t_decoder_if #(.CNT_W(CNT_W)) bus ();

  t_decoder #(
    .FILTER_CYCLES(FILTER_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: two-sample delay line, then a run length of samples disagreeing with the level.
  logic m_s1, m_s, m_level, m_t, m_r, m_f, m_ovf;
  int   m_run, m_cnt;
  logic m_fire;
  int   m_run_nx;

  always_comb begin
    m_fire   = 1'b0;
    m_run_nx = 0;
    if (m_s != m_level) begin
      if (m_run + 1 >= F_EFF) m_fire = 1'b1;
      else                    m_run_nx = m_run + 1;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m_s1 <= 1'b0; m_s <= 1'b0; m_level <= 1'b0; m_run <= 0;
      m_t <= 1'b0; m_r <= 1'b0; m_f <= 1'b0; m_cnt <= 0; m_ovf <= 1'b0;
    end else begin
      m_s1  <= bus.q_in;
      m_s   <= m_s1;
      m_run <= m_run_nx;
      m_t   <= m_fire;
      m_r   <= m_fire && !m_level;
      m_f   <= m_fire && m_level;
      if (m_fire) m_level <= !m_level;
      if (bus.cnt_clr) begin
        m_cnt <= m_fire ? 1 : 0;
        m_ovf <= 1'b0;
      end else if (m_fire) begin
        m_cnt <= (m_cnt + 1) % MOD;
        if (m_cnt == MOD - 1) m_ovf <= 1'b1;
      end
    end
  end

  function automatic logic [CNT_W+4:0] act_vec();
    return {bus.level, bus.t_out, bus.rise, bus.fall, bus.toggle_cnt, bus.ovf};
  endfunction

  function automatic logic [CNT_W+4:0] exp_vec();
    return {m_level, m_t, m_r, m_f, CNT_W'(m_cnt), m_ovf};
  endfunction

  // Advance n cycles, comparing all outputs with the reference after every edge.
  task automatic run_cycles(input string name, input int n,
                            output int pulses, output int rises, output int first_k);
    pulses  = 0;
    rises   = 0;
    first_k = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got {lvl,t,r,f,cnt,ovf}=%b want %b", name, k, act_vec(), exp_vec());
      end
      if (bus.t_out === 1'b1) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if (bus.rise === 1'b1) rises++;
    end
  endtask

  task automatic test_reset();
    int p, r, k;
    reset = 1'b1; bus.q_in = 1'b0; bus.cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (act_vec() !== '0) begin
        n_fail++;
        $display("FAIL reset_hold got %b want 0", act_vec());
      end
    end
    bus.q_in = 1'b1;
    reset    = 1'b0;
    run_cycles("reset_release", LAT + 4, p, r, k);
    n_cmp++;
    if (p !== 1 || r !== 1 || k !== LAT) begin
      n_fail++;
      $display("FAIL reset_rise pulses=%0d rises=%0d at=%0d want 1/1 at %0d", p, r, k, LAT);
    end
    n_cmp++;
    if ({bus.level, bus.toggle_cnt} !== {1'b1, CNT_W'(1)}) begin
      n_fail++;
      $display("FAIL reset_state level=%b cnt=%0d want 1/1", bus.level, bus.toggle_cnt);
    end
  endtask

  task automatic test_clean_toggles();
    int p, r, k;
    bus.cnt_clr = 1'b1;
    run_cycles("clean_clr", 1, p, r, k);
    bus.cnt_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.q_in = ~bus.q_in;
      run_cycles("clean_toggle", 10, p, r, k);
      n_cmp++;
      if (p !== 1 || k !== LAT || r !== int'(bus.q_in)) begin
        n_fail++;
        $display("FAIL clean_pulse n=%0d pulses=%0d at=%0d rises=%0d want 1 at %0d rises %0d",
                 i, p, k, r, LAT, int'(bus.q_in));
      end
    end
    n_cmp++;
    if (bus.toggle_cnt !== CNT_W'(6)) begin
      n_fail++;
      $display("FAIL clean_count got %0d want 6", bus.toggle_cnt);
    end
  endtask

  task automatic test_glitch();
    int p1, p2, r, k, exp_p;
    bus.q_in = 1'b0;
    run_cycles("glitch_settle", 12, p1, r, k);
    bus.cnt_clr = 1'b1;
    run_cycles("glitch_clr", 1, p1, r, k);
    bus.cnt_clr = 1'b0;
    bus.q_in = 1'b1;
    run_cycles("glitch_short_hi", 3, p1, r, k);
    bus.q_in = 1'b0;
    run_cycles("glitch_short_lo", 12, p2, r, k);
    exp_p = (F_EFF <= 3) ? 2 : 0;
    n_cmp++;
    if (p1 + p2 !== exp_p || bus.level !== 1'b0 || bus.toggle_cnt !== CNT_W'(exp_p)) begin
      n_fail++;
      $display("FAIL glitch_short pulses=%0d level=%b cnt=%0d want %0d/0/%0d",
               p1 + p2, bus.level, bus.toggle_cnt, exp_p, exp_p);
    end
    bus.q_in = 1'b1;
    run_cycles("glitch_long", 5 + 10, p1, r, k);
    n_cmp++;
    if (p1 !== 1 || r !== 1 || bus.level !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_long pulses=%0d rises=%0d level=%b want 1/1/1", p1, r, bus.level);
    end
  endtask

  task automatic test_wrap();
    int p, r, k;
    bus.cnt_clr = 1'b1;
    run_cycles("wrap_clr0", 1, p, r, k);
    bus.cnt_clr = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      bus.q_in = ~bus.q_in;
      run_cycles("wrap_toggle", LAT + 2, p, r, k);
      n_cmp++;
      if ({bus.toggle_cnt, bus.ovf} !== {CNT_W'(i % MOD), (i >= MOD)}) begin
        n_fail++;
        $display("FAIL wrap_step i=%0d cnt=%0d ovf=%b want %0d/%0d",
                 i, bus.toggle_cnt, bus.ovf, i % MOD, int'(i >= MOD));
      end
    end
    bus.cnt_clr = 1'b1;
    run_cycles("wrap_clr", 1, p, r, k);
    bus.cnt_clr = 1'b0;
    n_cmp++;
    if ({bus.toggle_cnt, bus.ovf} !== '0) begin
      n_fail++;
      $display("FAIL wrap_clear cnt=%0d ovf=%b want 0/0", bus.toggle_cnt, bus.ovf);
    end
  endtask

  task automatic test_simultaneous_clear();
    int p, r, k;
    bus.cnt_clr = 1'b1;
    run_cycles("simclr_clr0", 1, p, r, k);
    bus.cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.q_in = ~bus.q_in;
      run_cycles("simclr_fill", LAT + 2, p, r, k);
    end
    n_cmp++;
    if (bus.toggle_cnt !== CNT_W'(5)) begin
      n_fail++;
      $display("FAIL simclr_pre cnt=%0d want 5", bus.toggle_cnt);
    end
    bus.q_in = ~bus.q_in;
    run_cycles("simclr_wait", LAT - 1, p, r, k);
    bus.cnt_clr = 1'b1;
    run_cycles("simclr_edge", 1, p, r, k);
    bus.cnt_clr = 1'b0;
    n_cmp++;
    if ({bus.t_out, bus.toggle_cnt, bus.ovf} !== {1'b1, CNT_W'(1), 1'b0}) begin
      n_fail++;
      $display("FAIL simclr_fire t=%b cnt=%0d ovf=%b want 1/1/0", bus.t_out, bus.toggle_cnt, bus.ovf);
    end
    run_cycles("simclr_after", 4, p, r, k);
  endtask

  task automatic test_mid_reset();
    int p1, p2, p3, r, k, rst_edge;
    rst_edge = (F_EFF > 2) ? 4 : F_EFF + 1;
    bus.q_in = 1'b0;
    run_cycles("midrst_settle", 12, p1, r, k);
    bus.q_in = 1'b1;
    run_cycles("midrst_filter", rst_edge, p1, r, k);
    reset    = 1'b1;
    bus.q_in = 1'b0;
    run_cycles("midrst_hold", 2, p2, r, k);
    reset = 1'b0;
    run_cycles("midrst_after", 8, p3, r, k);
    n_cmp++;
    if (p1 + p2 + p3 !== 0 || bus.level !== 1'b0 || bus.toggle_cnt !== '0) begin
      n_fail++;
      $display("FAIL midrst pulses=%0d level=%b cnt=%0d want 0/0/0",
               p1 + p2 + p3, bus.level, bus.toggle_cnt);
    end
  endtask

  task automatic test_random();
    int p, r, k;
    for (int i = 0; i < 150; i++) begin
      bus.q_in    = 1'($urandom_range(0, 1));
      bus.cnt_clr = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 39) == 0);
      run_cycles("random", $urandom_range(1, 2 * F_EFF + 3), p, r, k);
    end
    reset       = 1'b0;
    bus.cnt_clr = 1'b0;
    run_cycles("random_tail", LAT + 4, p, r, k);
  endtask

  initial begin
    bus.q_in    = 1'b0;
    bus.cnt_clr = 1'b0;
    test_reset();
    test_clean_toggles();
    test_glitch();
    test_wrap();
    test_simultaneous_clear();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
